rvbranch_unit: RTL

Execute-stage branch resolution with a fetch-stage direction predictor, replacing the purely combinational resolver in the RISC-V pipeline. It predicts conditional branches in F from a table of 2-bit saturating counters (bimodal or gshare). In E it resolves the real outcome from ALU flags, raises a redirect on a mispredict or jump, and trains the table. It also keeps saturating branch/mispredict statistics for performance counters.

---
 rtl/rvbranch_pkg.sv | 37 +++
 rtl/rvbranch_bht.sv | 48 ++++
 rtl/rvbranch_unit.sv | 78 +++++++
 3 files changed

// File: rtl/rvbranch_pkg.sv
// rvbranch_pkg: condition codes, 2-bit predictor states and the
// condition decode shared by the branch unit and its table.
package rvbranch_pkg;

   localparam logic [3:0] COND_EQ  = 4'b0000;
   localparam logic [3:0] COND_NE  = 4'b0001;
   localparam logic [3:0] COND_LTU = 4'b0010;
   localparam logic [3:0] COND_GEU = 4'b0011;
   localparam logic [3:0] COND_GE  = 4'b1010;
   localparam logic [3:0] COND_LT  = 4'b1011;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bctr_t;

   // flags = {neg, zero, carry, overflow}; result = {taken, illegal}
   function automatic logic [1:0] cond_eval(
      input logic [3:0] cond,
      input logic [3:0] flags
   );
      logic ge;
      ge = (flags[3] == flags[0]);
      case (cond)
         COND_EQ:  return {flags[2], 1'b0};
         COND_NE:  return {~flags[2], 1'b0};
         COND_LTU: return {~flags[1], 1'b0};
         COND_GEU: return {flags[1], 1'b0};
         COND_GE:  return {ge, 1'b0};
         COND_LT:  return {~ge, 1'b0};
         default:  return 2'b01;
      endcase
   endfunction

endpackage

// File: rtl/rvbranch_bht.sv
// rvbranch_bht: table of 2-bit saturating counters with a combinational
// read port, a saturating training port and the global history register.
module rvbranch_bht
   import rvbranch_pkg::*;
#(
   parameter int  ENTRIES = 64,
   parameter int  GSHARE  = 0,
   parameter int  GHR_W   = 6,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] i_rd_base,
   output logic [IDX_W-1:0] o_rd_idx,
   output logic             o_rd_taken,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_taken
);

   bctr_t            r_tbl [ENTRIES];
   logic [GHR_W-1:0] r_ghr;
   logic [IDX_W-1:0] w_hist;
   logic [1:0]       w_rd;
   bctr_t            w_cur;

   assign w_hist     = (GSHARE != 0) ? IDX_W'(r_ghr) : '0;
   assign o_rd_idx   = i_rd_base ^ w_hist;
   assign w_rd       = r_tbl[o_rd_idx];
   assign o_rd_taken = w_rd[1];
   assign w_cur      = r_tbl[i_wr_idx];

   // F reads the pre-update entry; a same-cycle write is seen next cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= WNT;
         r_ghr <= '0;
      end else if (i_we) begin
         if (i_wr_taken && w_cur != ST)
            r_tbl[i_wr_idx] <= bctr_t'(w_cur + 2'd1);
         else if (!i_wr_taken && w_cur != SNT)
            r_tbl[i_wr_idx] <= bctr_t'(w_cur - 2'd1);
         if (GSHARE != 0)
            r_ghr <= GHR_W'({r_ghr, i_wr_taken});
      end
   end

endmodule

// File: rtl/rvbranch_unit.sv
// rvbranch_unit: F-stage direction prediction, E-stage branch resolution,
// redirect generation, predictor training and branch statistics.
module rvbranch_unit
   import rvbranch_pkg::*;
#(
   parameter int  ENTRIES = 64,
   parameter int  GSHARE  = 0,
   parameter int  GHR_W   = 6,
   parameter int  CNT_W   = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      PCF,
   output logic             PredTakenF,
   output logic [IDX_W-1:0] PredIdxF,
   input  logic [IDX_W-1:0] PredIdxE,
   input  logic             PredTakenE,
   input  logic             JumpE,
   input  logic             BranchE,
   input  logic             ValidE,
   input  logic             StallE,
   input  logic [3:0]       ALUFlags,
   input  logic [3:0]       CondE,
   output logic             RedirectE,
   output logic             RedirectTakenE,
   output logic             IllegalCondE,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] MispredCount
);

   logic             w_taken;
   logic             w_illegal;
   logic             w_mispred;
   logic             w_train;
   logic             w_unused_pc;
   logic [CNT_W-1:0] r_bcnt;
   logic [CNT_W-1:0] r_mcnt;

   assign {w_taken, w_illegal} = cond_eval(CondE, ALUFlags);
   assign w_unused_pc = ^{PCF[31:IDX_W+2], PCF[1:0]};

   assign w_mispred      = (w_taken != PredTakenE);
   assign IllegalCondE   = BranchE & ValidE & w_illegal;
   assign RedirectE      = ValidE & (JumpE | (BranchE & w_mispred));
   assign RedirectTakenE = JumpE | w_taken;
   // jumps take priority and never train the predictor
   assign w_train        = ValidE & ~StallE & BranchE & ~JumpE;

   rvbranch_bht #(
      .ENTRIES (ENTRIES),
      .GSHARE  (GSHARE),
      .GHR_W   (GHR_W)
   ) u_bht (
      .clk        (clk),
      .reset      (reset),
      .i_rd_base  (PCF[IDX_W+1:2]),
      .o_rd_idx   (PredIdxF),
      .o_rd_taken (PredTakenF),
      .i_we       (w_train),
      .i_wr_idx   (PredIdxE),
      .i_wr_taken (w_taken)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bcnt <= '0;
         r_mcnt <= '0;
      end else if (w_train) begin
         if (r_bcnt != '1) r_bcnt <= r_bcnt + 1'b1;
         if (w_mispred && r_mcnt != '1) r_mcnt <= r_mcnt + 1'b1;
      end
   end

   assign BranchCount  = r_bcnt;
   assign MispredCount = r_mcnt;

endmodule
